// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite slave backed by a word-addressed memory.
// One transaction at a time, byte strobes, SLVERR outside the memory.
package axi_lite_pkg;
  localparam int ADDR_WIDTH = 12;
  localparam int DATA_WIDTH = 32;
  localparam int STRB_WIDTH = 4;

  typedef logic [1:0] resp_t;
  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RADDR = 3'd1,
    RDATA = 3'd2,
    WADDR = 3'd3,
    WDATA = 3'd4,
    WRESP = 3'd5
  } state_type;
endpackage

module axi_lite_mem_slave
  import axi_lite_pkg::*;
#(
  parameter int MEM_WORDS = 1024
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [ADDR_WIDTH-1:0] ar_addr,
  input  logic                  ar_valid,
  output logic                  ar_ready,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic [1:0]            r_resp,
  output logic                  r_valid,
  input  logic                  r_ready,
  input  logic [ADDR_WIDTH-1:0] aw_addr,
  input  logic                  aw_valid,
  output logic                  aw_ready,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic [STRB_WIDTH-1:0] w_strb,
  input  logic                  w_valid,
  output logic                  w_ready,
  output logic [1:0]            b_resp,
  output logic                  b_valid,
  input  logic                  b_ready,
  output logic [2:0]            state
);

  localparam int IW = $clog2(MEM_WORDS);
  localparam logic GRANT_WRITE = 1'b1;

  state_type state_q, state_d;
  logic      last_grant, grant_d;
  logic [9:0] widx;
  logic      rd_ok, wr_ok;
  logic      unused_ok;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS] = '{default: '0};

  assign rd_ok = {22'd0, ar_addr[11:2]} < 32'(MEM_WORDS);
  assign wr_ok = {22'd0, widx} < 32'(MEM_WORDS);
  assign unused_ok = ^{ar_addr[1:0], aw_addr[1:0]};

  always_comb begin
    state_d = state_q;
    grant_d = last_grant;
    unique case (state_q)
      IDLE: begin
        if (ar_valid && aw_valid) begin
          grant_d = ~last_grant;
          state_d = (last_grant == GRANT_WRITE) ? RADDR : WADDR;
        end else if (ar_valid) begin
          state_d = RADDR;
        end else if (aw_valid) begin
          state_d = WADDR;
        end
      end
      RADDR: state_d = RDATA;
      RDATA: if (r_ready) state_d = IDLE;
      WADDR: state_d = WDATA;
      WDATA: if (w_valid) state_d = WRESP;
      WRESP: if (b_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= IDLE;
      last_grant <= GRANT_WRITE;
      widx       <= '0;
      r_data     <= '0;
      r_resp     <= RESP_OKAY;
      b_resp     <= RESP_OKAY;
    end else begin
      state_q    <= state_d;
      last_grant <= grant_d;
      if (state_q == RADDR) begin
        widx   <= ar_addr[11:2];
        r_data <= rd_ok ? mem[ar_addr[IW+1:2]] : '0;
        r_resp <= rd_ok ? RESP_OKAY : RESP_SLVERR;
      end
      if (state_q == WADDR)
        widx <= aw_addr[11:2];
      if (state_q == WDATA && w_valid)
        b_resp <= wr_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // Commit only at the W handshake; out-of-range writes are dropped.
  always_ff @(posedge aclk) begin
    if (state_q == WDATA && w_valid && wr_ok)
      for (int k = 0; k < STRB_WIDTH; k++)
        if (w_strb[k])
          mem[widx[IW-1:0]][8*k +: 8] <= w_data[8*k +: 8];
  end

  assign ar_ready = (state_q == RADDR);
  assign r_valid  = (state_q == RDATA);
  assign aw_ready = (state_q == WADDR);
  assign w_ready  = (state_q == WDATA);
  assign b_valid  = (state_q == WRESP);
  assign state    = state_q;

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Scoreboard bench for axi_lite_mem_slave (MEM_WORDS=16).
// Stimulus pushes expected R/B responses; a negedge monitor pops them.
module tb_axi_lite_mem_slave;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic        aclk = 1'b0;
  logic        areset;
  logic [11:0] ar_addr, aw_addr;
  logic        ar_valid, ar_ready;
  logic [31:0] r_data, w_data;
  logic [1:0]  r_resp, b_resp;
  logic        r_valid, r_ready;
  logic        aw_valid, aw_ready;
  logic [3:0]  w_strb;
  logic        w_valid, w_ready;
  logic        b_valid, b_ready;
  logic [2:0]  state;

  typedef struct {
    bit          rd;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int vectors = 0;
  int miscompares = 0;

  axi_lite_mem_slave #(.MEM_WORDS(16)) dut (
    .aclk(aclk), .areset(areset),
    .ar_addr(ar_addr), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready),
    .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
    .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .state(state)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic sig(input int w);
    case (w)
      0: return ar_ready;
      1: return aw_ready;
      2: return w_ready;
      3: return r_valid;
      default: return b_valid;
    endcase
  endfunction

  task automatic wait_hi(input int w, input string nm);
    for (int n = 0; n < 20; n++) begin
      @(negedge aclk);
      if (sig(w)) break;
    end
    if (!sig(w)) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout_%s: got 0 expected 1", nm);
    end
  endtask

  always @(negedge aclk) begin
    if (r_valid && r_ready) begin
      if (sbq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_r: got %h expected none", r_data);
      end else begin
        mon_e = sbq.pop_front();
        chk("r_kind", 32'(1), 32'(mon_e.rd));
        chk("r_data", r_data, mon_e.data);
        chk("r_resp", 32'(r_resp), 32'(mon_e.resp));
      end
    end
    if (b_valid && b_ready) begin
      if (sbq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_b: got %h expected none", b_resp);
      end else begin
        mon_e = sbq.pop_front();
        chk("b_kind", 32'(0), 32'(mon_e.rd));
        chk("b_resp", 32'(b_resp), 32'(mon_e.resp));
      end
    end
  end

  task automatic do_reset();
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
  endtask

  task automatic do_write(input logic [11:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [1:0] er,
                          input int hold);
    sbq.push_back('{1'b0, 32'd0, er});
    @(posedge aclk);
    #1;
    aw_valid = 1'b1; aw_addr = a;
    w_valid = 1'b1; w_data = d; w_strb = s;
    @(negedge aclk); chk("aw_ready_n", 32'(aw_ready), 0);
    @(negedge aclk); chk("aw_ready_n1", 32'(aw_ready), 1);
    chk("w_ready_early", 32'(w_ready), 0);
    @(posedge aclk); #1 aw_valid = 1'b0;
    @(negedge aclk); chk("w_ready_n2", 32'(w_ready), 1);
    @(posedge aclk); #1 w_valid = 1'b0;
    @(negedge aclk); chk("b_valid_lat", 32'(b_valid), 1);
    repeat (hold) begin
      @(negedge aclk);
      chk("b_valid_hold", 32'(b_valid), 1);
      chk("b_resp_hold", 32'(b_resp), 32'(er));
    end
    @(posedge aclk); #1 b_ready = 1'b1;
    @(posedge aclk); #1 b_ready = 1'b0;
  endtask

  task automatic do_read(input logic [11:0] a, input logic [31:0] ed,
                         input logic [1:0] er, input int hold);
    sbq.push_back('{1'b1, ed, er});
    @(posedge aclk);
    #1 ar_valid = 1'b1; ar_addr = a;
    @(negedge aclk); chk("ar_ready_n", 32'(ar_ready), 0);
    @(negedge aclk); chk("ar_ready_n1", 32'(ar_ready), 1);
    @(posedge aclk); #1 ar_valid = 1'b0;
    @(negedge aclk); chk("r_valid_n2", 32'(r_valid), 1);
    repeat (hold) begin
      @(negedge aclk);
      chk("r_valid_hold", 32'(r_valid), 1);
      chk("r_data_hold", r_data, ed);
    end
    @(posedge aclk); #1 r_ready = 1'b1;
    @(posedge aclk); #1 r_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ar_addr = '0; ar_valid = 0; r_ready = 0;
    aw_addr = '0; aw_valid = 0; w_data = '0; w_strb = '0;
    w_valid = 0; b_ready = 0;
    do_reset();
    @(negedge aclk);
    chk("rst_state", 32'(state), 0);
    chk("rst_ar_ready", 32'(ar_ready), 0);
    chk("rst_r_valid", 32'(r_valid), 0);
    chk("rst_b_valid", 32'(b_valid), 0);
    chk("rst_r_data", r_data, 0);
    chk("rst_resp", 32'({r_resp, b_resp}), 0);

    do_write(12'h004, 32'hDEADBEEF, 4'hF, OKAY, 0);
    do_read(12'h004, 32'hDEADBEEF, OKAY, 0);

    do_write(12'h014, 32'h11223344, 4'hF, OKAY, 0);
    do_write(12'h014, 32'hAABBCCDD, 4'b0101, OKAY, 0);
    do_read(12'h014, 32'h11BB33DD, OKAY, 0);
    do_write(12'h014, 32'hFFFFFFFF, 4'h0, OKAY, 0);
    do_read(12'h017, 32'h11BB33DD, OKAY, 0);

    do_write(12'h040, 32'h12345678, 4'hF, SLVERR, 0);
    do_read(12'h040, 32'h0, SLVERR, 0);
    do_read(12'h000, 32'h0, OKAY, 0);
    do_read(12'hFFC, 32'h0, SLVERR, 0);
    do_read(12'h03C, 32'h0, OKAY, 0);

    do_read(12'h004, 32'hDEADBEEF, OKAY, 5);
    do_write(12'h008, 32'h55AA55AA, 4'hF, OKAY, 5);
    do_read(12'h008, 32'h55AA55AA, OKAY, 0);

    // Reset during RDATA
    @(posedge aclk); #1 ar_valid = 1'b1; ar_addr = 12'h004;
    @(posedge aclk); #1;
    @(posedge aclk); #1 ar_valid = 1'b0;
    @(negedge aclk); chk("pre_rst_r_valid", 32'(r_valid), 1);
    #1 areset = 1'b1;
    #1;
    chk("async_r_valid", 32'(r_valid), 0);
    chk("async_ar_ready", 32'(ar_ready), 0);
    chk("async_b_valid", 32'(b_valid), 0);
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    @(negedge aclk); chk("post_rst_state", 32'(state), 0);

    // Reset in WDATA before the W handshake: write must not land
    @(posedge aclk);
    #1 aw_valid = 1'b1; aw_addr = 12'h008;
    w_data = 32'h0BADBAD0; w_strb = 4'hF;
    @(negedge aclk); @(negedge aclk);
    @(posedge aclk); #1 aw_valid = 1'b0;
    @(negedge aclk); chk("pre_rst_w_ready", 32'(w_ready), 1);
    #1 areset = 1'b1;
    #1 chk("async_w_ready", 32'(w_ready), 0);
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    do_read(12'h008, 32'h55AA55AA, OKAY, 0);

    // Contention after reset: READ first, then WRITE
    do_reset();
    sbq.push_back('{1'b1, 32'h0, OKAY});
    @(posedge aclk);
    #1;
    ar_valid = 1'b1; ar_addr = 12'h020;
    aw_valid = 1'b1; aw_addr = 12'h020;
    w_valid = 1'b1; w_data = 32'hCAFEF00D; w_strb = 4'hF;
    @(negedge aclk); @(negedge aclk);
    chk("grant1_ar", 32'(ar_ready), 1);
    chk("grant1_aw", 32'(aw_ready), 0);
    chk("grant1_w", 32'(w_ready), 0);
    @(posedge aclk); #1 ar_valid = 1'b0;
    @(negedge aclk); chk("grant1_r_valid", 32'(r_valid), 1);
    @(posedge aclk); #1 r_ready = 1'b1; ar_valid = 1'b1;
    @(posedge aclk); #1 r_ready = 1'b0;
    sbq.push_back('{1'b0, 32'h0, OKAY});
    @(negedge aclk); @(negedge aclk);
    chk("grant2_aw", 32'(aw_ready), 1);
    chk("grant2_ar", 32'(ar_ready), 0);
    @(posedge aclk); #1 aw_valid = 1'b0;
    wait_hi(2, "w_ready");
    @(posedge aclk); #1 w_valid = 1'b0;
    wait_hi(4, "b_valid");
    @(posedge aclk); #1 b_ready = 1'b1;
    @(posedge aclk); #1 b_ready = 1'b0;
    sbq.push_back('{1'b1, 32'hCAFEF00D, OKAY});
    wait_hi(0, "ar_ready");
    @(posedge aclk); #1 ar_valid = 1'b0;
    wait_hi(3, "r_valid");
    @(posedge aclk); #1 r_ready = 1'b1;
    @(posedge aclk); #1 r_ready = 1'b0;

    repeat (4) @(posedge aclk);
    chk("sb_empty", 32'(sbq.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
